mio_responder: RTL and testbench

Memory/IO responder on the far end of the multicycle CPU's memory bus. It accepts read and write requests qualified by the controller's memory strobes and size code, and drives a synchronous word RAM or the memory-mapped IO port. It performs size, sign and byte-swap handling on the data, then reports completion on `mio_ready`, which the controller samples while fetching.

---
 rtl/mio_responder_pkg.sv | 33 +++
 rtl/mio_data_align.sv | 54 +++++
 rtl/mio_responder.sv | 167 ++++++++++++++++
 tb/tb_mio_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mio_responder_pkg.sv
// Shared definitions for the memory/IO responder: size codes, FSM states,
// default IO window and byte-swap helpers.
package mio_responder_pkg;

    typedef enum logic [2:0] {
        SZ_FULL   = 3'b000,
        SZ_FULLX  = 3'b001,
        SZ_HALF   = 3'b010,
        SZ_HALFX  = 3'b011,
        SZ_HALFU  = 3'b100,
        SZ_HALFUX = 3'b101
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_RAM = 3'd1,
        ST_WR_RAM = 3'd2,
        ST_RD_IO  = 3'd3,
        ST_WR_IO  = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    localparam logic [31:0] IO_BASE_DEF = 32'hF000_0000;

    function automatic logic [15:0] swap16(input logic [15:0] h);
        return {h[7:0], h[15:8]};
    endfunction

    function automatic logic [31:0] swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/mio_data_align.sv
// Combinational lane steering: store byte enables/lane data and load
// extraction (half select, byte swap, sign/zero extension).
module mio_data_align
    import mio_responder_pkg::*;
(
    input  logic [2:0]  st_ctrl,
    input  logic        st_hi,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_lanes,
    input  logic [2:0]  ld_ctrl,
    input  logic        ld_hi,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [15:0] st_half;
    logic [15:0] ld_half;
    logic [15:0] ld_swap;

    always_comb begin
        st_half  = st_data[15:0];
        st_be    = 4'b1111;
        st_lanes = st_data;
        case (st_ctrl)
            SZ_FULLX: st_lanes = swap32(st_data);
            SZ_HALF, SZ_HALFU: begin
                st_lanes = {st_half, st_half};
                st_be    = st_hi ? 4'b1100 : 4'b0011;
            end
            SZ_HALFX, SZ_HALFUX: begin
                st_half  = swap16(st_data[15:0]);
                st_lanes = {st_half, st_half};
                st_be    = st_hi ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_half = ld_hi ? ld_word[31:16] : ld_word[15:0];
        ld_swap = swap16(ld_half);
        ld_data = ld_word;
        case (ld_ctrl)
            SZ_FULLX:  ld_data = swap32(ld_word);
            SZ_HALF:   ld_data = {{16{ld_half[15]}}, ld_half};
            SZ_HALFX:  ld_data = {{16{ld_swap[15]}}, ld_swap};
            SZ_HALFU:  ld_data = {16'h0000, ld_half};
            SZ_HALFUX: ld_data = {16'h0000, ld_swap};
            default: ;
        endcase
    end

endmodule

// File: rtl/mio_responder.sv
// Memory/IO responder: accepts one bus request at a time, drives a synchronous
// word RAM or the memory-mapped IO port, and reports completion on mio_ready.
module mio_responder
    import mio_responder_pkg::*;
#(
    parameter int          RAM_LATENCY = 2,
    parameter int          RAM_AW      = 10,
    parameter logic [31:0] IO_BASE     = IO_BASE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_mio,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [2:0]        ram_ctrl,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              mio_ready,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              io_rd,
    output logic              io_wr,
    output logic [31:0]       io_addr,
    output logic [31:0]       io_wdata,
    input  logic [31:0]       io_rdata
);

    localparam logic [2:0] LAT = 3'(RAM_LATENCY);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ram_en_q, ram_en_d;
    logic [3:0]  ram_we_q, ram_we_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic        io_rd_q, io_rd_d;
    logic        io_wr_q, io_wr_d;

    logic [3:0]  st_be;
    logic [31:0] st_lanes;
    logic [31:0] ld_word;
    logic [31:0] ld_data;
    logic        is_io;

    // Store path looks at the live request so byte enables can be registered
    // on the accepting edge; load path uses the latched request.
    mio_data_align u_align (
        .st_ctrl  (ram_ctrl),
        .st_hi    (addr[1]),
        .st_data  (wdata),
        .st_be    (st_be),
        .st_lanes (st_lanes),
        .ld_ctrl  (ctrl_q),
        .ld_hi    (addr_q[1]),
        .ld_word  (ld_word),
        .ld_data  (ld_data)
    );

    assign ld_word = (state_q == ST_RD_IO) ? io_rdata : ram_rdata;
    assign is_io   = (addr[31:28] == IO_BASE[31:28]);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ctrl_d      = ctrl_q;
        rdata_d     = rdata_q;
        ram_wdata_d = ram_wdata_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 4'b0000;
        io_rd_d     = 1'b0;
        io_wr_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_mio && (mem_rd || mem_wr)) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    ctrl_d  = ram_ctrl;
                    cnt_d   = 3'd0;
                    if (mem_wr) begin
                        if (is_io) begin
                            state_d = ST_WR_IO;
                            io_wr_d = 1'b1;
                        end else begin
                            state_d     = ST_WR_RAM;
                            ram_en_d    = 1'b1;
                            ram_we_d    = st_be;
                            ram_wdata_d = st_lanes;
                        end
                    end else if (is_io) begin
                        state_d = ST_RD_IO;
                        io_rd_d = 1'b1;
                    end else begin
                        state_d  = ST_RD_RAM;
                        ram_en_d = 1'b1;
                    end
                end
            end
            ST_RD_RAM: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAT) begin
                    rdata_d = ld_data;
                    state_d = ST_DONE;
                end
            end
            ST_RD_IO: begin
                // io_rdata is valid one cycle after the io_rd pulse
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd1) begin
                    rdata_d = ld_data;
                    state_d = ST_DONE;
                end
            end
            ST_WR_RAM, ST_WR_IO: state_d = ST_DONE;
            ST_DONE:             state_d = ST_IDLE;
            default:             state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            ctrl_q      <= 3'd0;
            rdata_q     <= 32'h0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 4'b0000;
            ram_wdata_q <= 32'h0;
            io_rd_q     <= 1'b0;
            io_wr_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ctrl_q      <= ctrl_d;
            rdata_q     <= rdata_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            io_rd_q     <= io_rd_d;
            io_wr_q     <= io_wr_d;
        end
    end

    assign mio_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign rdata     = rdata_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = addr_q[RAM_AW+1:2];
    assign ram_wdata = ram_wdata_q;
    assign io_rd     = io_rd_q;
    assign io_wr     = io_wr_q;
    assign io_addr   = addr_q;
    assign io_wdata  = wdata_q;

endmodule

// File: tb/tb_mio_responder.sv
// Scoreboard bench for mio_responder: a latency-accurate RAM/IO model, a
// completion monitor popping expected rdata/busy length, and directed requests.
module tb_mio_responder;

    localparam int L = 2;

    typedef struct {
        logic [31:0] rd;
        int          busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_mio, mem_rd, mem_wr;
    logic [2:0]  ram_ctrl;
    logic [31:0] addr, wdata, rdata;
    logic        mio_ready, ram_en;
    logic [3:0]  ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        io_rd, io_wr;
    logic [31:0] io_addr, io_wdata, io_rdata;

    logic [31:0] mem [0:63];
    logic [31:0] pipe [1:L];
    logic [31:0] io_val;
    logic [31:0] last_wd;
    logic [3:0]  last_we;
    int          n_ram_en = 0, n_io_rd = 0, n_io_wr = 0;

    exp_t        exp_q[$];
    logic [31:0] cur;
    int          n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    mio_responder #(.RAM_LATENCY(L), .RAM_AW(10), .IO_BASE(32'hF000_0000)) dut (
        .clk(clk), .rst(rst), .cpu_mio(cpu_mio), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .ram_ctrl(ram_ctrl), .addr(addr), .wdata(wdata), .rdata(rdata),
        .mio_ready(mio_ready), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .io_rd(io_rd), .io_wr(io_wr),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata)
    );

    // synchronous RAM with L cycles from ram_en to ram_rdata
    always @(posedge clk) begin
        if (ram_en && ram_we == 4'b0000) pipe[1] <= mem[ram_addr[5:0]];
        for (int i = 2; i <= L; i++) pipe[i] <= pipe[i-1];
        if (ram_en)
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr[5:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
        if (ram_en) n_ram_en <= n_ram_en + 1;
        if (ram_en && ram_we != 4'b0000) begin
            last_we <= ram_we;
            last_wd <= ram_wdata;
        end
        if (io_rd) begin
            n_io_rd  <= n_io_rd + 1;
            io_rdata <= io_val;
        end
        if (io_wr) n_io_wr <= n_io_wr + 1;
    end
    assign ram_rdata = pipe[L];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // completion monitor: counts busy cycles, pops expectation on the DONE cycle
    initial begin
        int   busy;
        exp_t e;
        busy = 0;
        forever begin
            @(negedge clk);
            if (rst) busy = 0;
            else if (!mio_ready) busy++;
            else if (busy > 0) begin
                if (exp_q.size() == 0) chk("spurious_done", busy, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("busy_cycles", busy, e.busy);
                    chk("rdata", rdata, e.rd);
                end
                busy = 0;
            end
        end
    end

    task automatic req(input logic mio, input logic rd, input logic wr, input logic [2:0] ctrl,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input int exp_busy);
        int n;
        @(negedge clk);
        cpu_mio = mio; mem_rd = rd; mem_wr = wr; ram_ctrl = ctrl; addr = a; wdata = d;
        if (mio && (rd || wr)) exp_q.push_back('{exp_rd, exp_busy});
        @(negedge clk);
        // inputs are don't-care once accepted
        cpu_mio = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        ram_ctrl = 3'($urandom); addr = $urandom; wdata = $urandom;
        if (!(mio && (rd || wr))) begin
            repeat (3) begin
                chk("idle_ready", mio_ready, 1'b1);
                @(negedge clk);
            end
        end else begin
            n = 0;
            while (!mio_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) chk("done_timeout", 1'b1, 1'b0);
            @(negedge clk);
        end
    endtask

    logic [2:0]  h_ctrl [4] = '{3'b010, 3'b100, 3'b011, 3'b101};
    logic [31:0] h_addr [4] = '{32'h22, 32'h20, 32'h20, 32'h22};
    logic [31:0] h_exp  [4] = '{32'hFFFF_8123, 32'h0000_F0E1, 32'hFFFF_E1F0, 32'h0000_2381};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0, r0, w0;
        rst = 1'b1; cpu_mio = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        ram_ctrl = 3'd0; addr = 32'h0; wdata = 32'h0; io_val = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'h8123_4567;
        mem[8] = 32'h8123_F0E1;
        repeat (3) @(negedge clk);
        chk("rst_ready", mio_ready, 1'b1);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ctrl", {ram_en, ram_we, io_rd, io_wr}, 7'h0);
        rst = 1'b0;
        cur = 32'h0;

        e0 = n_ram_en;
        req(1, 1, 0, 3'b000, 32'h10, 32'h0, 32'h8123_4567, L + 1); cur = 32'h8123_4567;
        chk("ram_en_pulses", n_ram_en - e0, 1);

        for (int i = 0; i < 4; i++) begin
            req(1, 1, 0, h_ctrl[i], h_addr[i], 32'h0, h_exp[i], L + 1);
            cur = h_exp[i];
        end
        req(1, 1, 0, 3'b001, 32'h13, 32'h0, 32'h6745_2381, L + 1);
        req(1, 1, 0, 3'b110, 32'h10, 32'h0, 32'h8123_4567, L + 1); cur = 32'h8123_4567;

        req(1, 0, 1, 3'b001, 32'h30, 32'h1122_3344, cur, 1);
        chk("fullx_we", last_we, 4'hF);
        chk("fullx_wd", last_wd, 32'h4433_2211);
        req(1, 0, 1, 3'b010, 32'h06, 32'h0000_ABCD, cur, 1);
        chk("half_we", last_we, 4'hC);
        chk("half_wd_hi", last_wd[31:16], 16'hABCD);
        req(1, 0, 1, 3'b101, 32'h08, 32'h0000_1234, cur, 1);
        chk("halfux_we", last_we, 4'h3);
        chk("halfux_wd_lo", last_wd[15:0], 16'h3412);
        req(1, 1, 0, 3'b000, 32'h04, 32'h0, 32'hABCD_0000, L + 1);
        req(1, 1, 0, 3'b000, 32'h30, 32'h0, 32'h4433_2211, L + 1); cur = 32'h4433_2211;

        e0 = n_ram_en; r0 = n_io_rd; io_val = 32'h0000_005A;
        req(1, 1, 0, 3'b000, 32'hF000_0004, 32'h0, 32'h0000_005A, 2); cur = 32'h0000_005A;
        chk("io_rd_pulses", n_io_rd - r0, 1);
        chk("io_rd_no_ram", n_ram_en - e0, 0);
        chk("io_addr", io_addr, 32'hF000_0004);

        w0 = n_io_wr;
        req(1, 0, 1, 3'b010, 32'hF000_0008, 32'hDEAD_BEEF, cur, 1);
        chk("io_wr_pulses", n_io_wr - w0, 1);
        chk("io_wdata_raw", io_wdata, 32'hDEAD_BEEF);
        chk("io_wr_no_ram", n_ram_en - e0, 0);

        req(1, 1, 1, 3'b000, 32'h40, 32'hCAFE_F00D, cur, 1);
        chk("rdwr_we", last_we, 4'hF);
        chk("rdwr_wd", last_wd, 32'hCAFE_F00D);
        req(1, 1, 0, 3'b000, 32'h40, 32'h0, 32'hCAFE_F00D, L + 1); cur = 32'hCAFE_F00D;

        e0 = n_ram_en;
        req(0, 1, 0, 3'b000, 32'h10, 32'h0, cur, 0);
        chk("no_mio_no_access", n_ram_en - e0, 0);

        // reset in the second RD_RAM cycle aborts the read without a DONE
        @(negedge clk);
        cpu_mio = 1'b1; mem_rd = 1'b1; ram_ctrl = 3'b000; addr = 32'h10;
        @(posedge clk); #1;
        cpu_mio = 1'b0; mem_rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_ready", mio_ready, 1'b1);
        chk("abort_rdata", rdata, 32'h0);
        chk("abort_ram_en", ram_en, 1'b0);
        cur = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        req(1, 1, 0, 3'b100, 32'h20, 32'h0, 32'h0000_F0E1, L + 1);

        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
